// File: rtl/compli_safe_scan_ctrl.sv
// Round-robin complementary-pair safety supervisor with debounced demands and safe-state FSM.
// Optional power-up checker self-test is compiled in with `define COMPLI_SELFTEST_EN.
module compli_safe_scan_ctrl #(
  parameter int N_CH     = 4,
  parameter int DEBOUNCE = 3,
  parameter int IDX_W    = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*N_CH-1:0] ch_pn,
  input  logic              fault_clr,
  output logic [1:0]        safe_ok,
  output logic [N_CH-1:0]   fault_ch,
  output logic              enc_fault,
  output logic [1:0]        state,
  output logic [IDX_W-1:0]  scan_idx,
  output logic              selftest_fail
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] ST_INIT     = 2'b00;
  localparam logic [1:0] ST_RUN      = 2'b01;
  localparam logic [1:0] ST_FAULT    = 2'b10;
  localparam logic [1:0] ST_SELFTEST = 2'b11;
`ifdef COMPLI_SELFTEST_EN
  localparam logic [1:0] ST_ENTRY    = ST_SELFTEST;
`else
  localparam logic [1:0] ST_ENTRY    = ST_INIT;
`endif

  localparam logic [1:0]       SAFE_RUN  = 2'b10;
  localparam logic [1:0]       SAFE_STOP = 2'b01;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] cnt_r [N_CH];
  logic [N_CH-1:0]  flag_r;
  logic             last_clean_r;

  logic [1:0]       ch_code;
  logic [1:0]       code;
  logic             cls_valid;
  logic             cls_demand;
  logic             cls_enc;
  logic             scan_active;
  logic             at_last;
  logic             fault_ev;
  logic             scan_clean;
  logic             clear_all;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_new;
  logic [N_CH-1:0]  flag_new;
  logic [1:0]       state_nxt;

  assign ch_code = ch_pn[{scan_idx, 1'b0} +: 2];

`ifdef COMPLI_SELFTEST_EN
  logic [1:0] st_step_r;
  logic [1:0] st_code;
  logic [2:0] st_exp;
  logic       st_mismatch;

  // Self-test pattern and its expected {valid, demand, enc} classification.
  always_comb begin
    st_code = 2'b00;
    st_exp  = 3'b001;
    case (st_step_r)
      2'd0:    begin st_code = 2'b00; st_exp = 3'b001; end
      2'd1:    begin st_code = 2'b11; st_exp = 3'b001; end
      2'd2:    begin st_code = 2'b01; st_exp = 3'b010; end
      2'd3:    begin st_code = 2'b10; st_exp = 3'b100; end
      default: begin st_code = 2'b00; st_exp = 3'b001; end
    endcase
  end

  assign code        = (state == ST_SELFTEST) ? st_code : ch_code;
  assign st_mismatch = (state == ST_SELFTEST) &&
                       ({cls_valid, cls_demand, cls_enc} != st_exp);
`else
  assign code = ch_code;
`endif

  // The one shared complementary-pair checker.
  assign cls_valid  = (code == 2'b10);
  assign cls_demand = (code == 2'b01);
  assign cls_enc    = (code[1] == code[0]);

  // Debounce and scan-valid bookkeeping for the channel evaluated at this edge.
  always_comb begin
    scan_active = (state != ST_SELFTEST);
    at_last     = (scan_idx == LAST_IDX);
    cnt_cur     = cnt_r[scan_idx];
    cnt_inc     = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
    if (cls_valid) begin
      cnt_new = {CNT_W{1'b0}};
    end else if (cls_demand) begin
      cnt_new = cnt_inc;
    end else begin
      cnt_new = cnt_cur;
    end
    fault_ev = scan_active && (cls_enc || (cls_demand && (cnt_inc == CNT_MAX)));
    flag_new = flag_r;
    flag_new[scan_idx] = cls_valid;
    scan_clean = scan_active && at_last && (&flag_new);
  end

  // Safe-state FSM; a fault on the same edge as a clear keeps FAULT.
  always_comb begin
    state_nxt = ST_FAULT;
    clear_all = 1'b0;
    case (state)
      ST_INIT: begin
        if (scan_clean) state_nxt = ST_RUN;
        else            state_nxt = ST_INIT;
      end
      ST_RUN: begin
        if (fault_ev) state_nxt = ST_FAULT;
        else          state_nxt = ST_RUN;
      end
      ST_FAULT: begin
        if (fault_clr && last_clean_r && !fault_ev && !selftest_fail) begin
          state_nxt = ST_ENTRY;
          clear_all = 1'b1;
        end else begin
          state_nxt = ST_FAULT;
        end
      end
`ifdef COMPLI_SELFTEST_EN
      ST_SELFTEST: begin
        if (st_mismatch)             state_nxt = ST_FAULT;
        else if (st_step_r == 2'd3)  state_nxt = ST_INIT;
        else                         state_nxt = ST_SELFTEST;
      end
`endif
      default: state_nxt = ST_FAULT;
    endcase
  end

  // State, scan position, counters, flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ENTRY;
      safe_ok      <= SAFE_STOP;
      scan_idx     <= {IDX_W{1'b0}};
      fault_ch     <= {N_CH{1'b0}};
      enc_fault    <= 1'b0;
      flag_r       <= {N_CH{1'b0}};
      last_clean_r <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      state   <= state_nxt;
      safe_ok <= (state_nxt == ST_RUN) ? SAFE_RUN : SAFE_STOP;
      if (!scan_active || (state_nxt == ST_SELFTEST) || at_last) begin
        scan_idx <= {IDX_W{1'b0}};
      end else begin
        scan_idx <= scan_idx + IDX_W'(1);
      end
      if (scan_active) begin
        flag_r <= flag_new;
        if (at_last) last_clean_r <= &flag_new;
      end
      if (clear_all) begin
        fault_ch  <= {N_CH{1'b0}};
        enc_fault <= 1'b0;
        for (int i = 0; i < N_CH; i++) cnt_r[i] <= {CNT_W{1'b0}};
      end else begin
        if (scan_active) cnt_r[scan_idx] <= cnt_new;
        if (fault_ev) begin
          fault_ch[scan_idx] <= 1'b1;
          if (cls_enc) enc_fault <= 1'b1;
        end
      end
    end
  end

`ifdef COMPLI_SELFTEST_EN
  // Self-test sequencing; a failure is sticky until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_step_r     <= 2'd0;
      selftest_fail <= 1'b0;
    end else begin
      if ((state == ST_SELFTEST) && (state_nxt == ST_SELFTEST)) st_step_r <= st_step_r + 2'd1;
      else                                                      st_step_r <= 2'd0;
      if (st_mismatch) selftest_fail <= 1'b1;
    end
  end
`else
  assign selftest_fail = 1'b0;
`endif

endmodule

// File: tb/tb_compli_safe_scan_ctrl.sv
// Scoreboard bench for compli_safe_scan_ctrl: directed test-plan scenarios plus random pair codes,
// checked every cycle against a rule-level reference model.
module tb_compli_safe_scan_ctrl;
  localparam int N_CH     = 4;
  localparam int DEBOUNCE = 3;
  localparam int IDX_W    = 2;
  localparam int EW       = 2 + 2 + N_CH + 1 + IDX_W + 1;
`ifdef COMPLI_SELFTEST_EN
  localparam int ENTRY  = 3;
  localparam int ST_CYC = 4;
`else
  localparam int ENTRY  = 0;
  localparam int ST_CYC = 0;
`endif

  logic              clk;
  logic              rst;
  logic [2*N_CH-1:0] ch_pn;
  logic              fault_clr;
  logic [1:0]        safe_ok;
  logic [N_CH-1:0]   fault_ch;
  logic              enc_fault;
  logic [1:0]        state;
  logic [IDX_W-1:0]  scan_idx;
  logic              selftest_fail;

  compli_safe_scan_ctrl #(.N_CH(N_CH), .DEBOUNCE(DEBOUNCE), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .ch_pn(ch_pn), .fault_clr(fault_clr),
    .safe_ok(safe_ok), .fault_ch(fault_ch), .enc_fault(enc_fault),
    .state(state), .scan_idx(scan_idx), .selftest_fail(selftest_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q [$];

  // Reference model: 0 INIT, 1 RUN, 2 FAULT, 3 SELFTEST; m_run = consecutive demands seen.
  int            m_state, m_idx, m_st_step;
  int            m_run [N_CH];
  bit            m_ok  [N_CH];
  bit            m_last_clean, m_enc, m_stf;
  logic [N_CH-1:0] m_fch;

  task automatic model_reset();
    m_state = ENTRY; m_idx = 0; m_st_step = 0;
    m_last_clean = 0; m_enc = 0; m_stf = 0; m_fch = '0;
    foreach (m_run[i]) begin m_run[i] = 0; m_ok[i] = 0; end
  endtask

  task automatic model_step(input logic [2*N_CH-1:0] pn, input logic clr);
    int ns;
    bit valid, demand, enc, fault, all_ok;
    ns = m_state;
    if (m_state == 3) begin
      m_st_step++;
      if (m_st_step == 4) begin ns = 0; m_st_step = 0; end
      m_idx = 0;
    end else begin
      valid  = (pn[2*m_idx+1] == 1'b1) && (pn[2*m_idx] == 1'b0);
      demand = (pn[2*m_idx+1] == 1'b0) && (pn[2*m_idx] == 1'b1);
      enc    = (pn[2*m_idx+1] == pn[2*m_idx]);
      if (valid) m_run[m_idx] = 0;
      else if (demand && m_run[m_idx] < DEBOUNCE) m_run[m_idx]++;
      fault = enc || (demand && m_run[m_idx] == DEBOUNCE);
      m_ok[m_idx] = valid;
      all_ok = 1;
      foreach (m_ok[i]) if (!m_ok[i]) all_ok = 0;
      if (fault) begin
        m_fch[m_idx] = 1'b1;
        if (enc) m_enc = 1;
      end
      if (m_state == 0 && m_idx == N_CH-1 && all_ok) ns = 1;
      if (m_state == 1 && fault) ns = 2;
      if (m_state == 2 && clr && m_last_clean && !fault && !m_stf) begin
        ns = ENTRY; m_fch = '0; m_enc = 0;
        foreach (m_run[i]) m_run[i] = 0;
      end
      if (m_idx == N_CH-1) m_last_clean = all_ok;
      m_idx = (ns == 3) ? 0 : (m_idx + 1) % N_CH;
    end
    m_state = ns;
  endtask

  function automatic logic [EW-1:0] model_vec();
    return {2'(m_state), (m_state == 1) ? 2'b10 : 2'b01, m_fch, m_enc, IDX_W'(m_idx), m_stf};
  endfunction

  // Monitor: pop one expectation per edge whenever the driver pushed one.
  always @(posedge clk) begin
    logic [EW-1:0] e, a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state, safe_ok, fault_ch, enc_fault, scan_idx, selftest_fail};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t {state,safe_ok,fault_ch,enc,idx,stf} actual=%b expected=%b",
                 $time, a, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst) begin
        model_step(ch_pn, fault_clr);
        exp_q.push_back(model_vec());
      end
      @(negedge clk);
      fault_clr = 1'b0;
    end
  endtask

  task automatic set_ch(input int i, input logic [1:0] c);
    ch_pn[2*i +: 2] = c;
  endtask

  task automatic wait_idx(input int k);
    int g = 0;
    while (m_idx != k && g < 2*N_CH + ST_CYC) begin cyc(1); g++; end
    if (m_idx != k) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idx bound expired actual=%0d expected=%0d", m_idx, k);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, ENTRY);
    chk({tag, "_safe_ok"}, safe_ok, 2'b01);
    chk({tag, "_fault_ch"}, fault_ch, '0);
    chk({tag, "_enc"}, enc_fault, 1'b0);
    chk({tag, "_idx"}, scan_idx, '0);
    chk({tag, "_stf"}, selftest_fail, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ch_pn = {N_CH{2'b10}}; fault_clr = 1'b0;
    model_reset();
    #2;
    chk_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Power-up clean scan
    cyc(N_CH - 1 + ST_CYC);
    chk("powerup_not_yet_run", state, 0);
    cyc(1);
    chk("powerup_run", state, 1);
    chk("powerup_safe_ok", safe_ok, 2'b10);

    // Demand for two evaluations only
    wait_idx(2); set_ch(2, 2'b01); cyc(5); set_ch(2, 2'b10); cyc(8);
    chk("short_demand_run", state, 1);
    chk("short_demand_fault_ch", fault_ch, 4'b0000);

    // Held demand: FAULT exactly at the third evaluation
    wait_idx(2); set_ch(2, 2'b01); cyc(8);
    chk("held_demand_before", state, 1);
    cyc(1);
    chk("held_demand_state", state, 2);
    chk("held_demand_safe_ok", safe_ok, 2'b01);
    chk("held_demand_fault_ch", fault_ch, 4'b0100);

    // Clear ignored while demand persists, accepted after a clean scan
    fault_clr = 1'b1; cyc(3);
    chk("clr_dirty_state", state, 2);
    set_ch(2, 2'b10); cyc(2*N_CH);
    fault_clr = 1'b1; cyc(1);
    chk("clr_clean_state", state, ENTRY);
    chk("clr_clean_fault_ch", fault_ch, 4'b0000);
    cyc(2*N_CH + ST_CYC);
    chk("clr_then_run", state, 1);

    // Encoding fault bypasses debounce
    wait_idx(1); set_ch(1, 2'b11); cyc(1);
    chk("enc_state", state, 2);
    chk("enc_fault_ch", fault_ch, 4'b0010);
    chk("enc_flag", enc_fault, 1'b1);
    set_ch(1, 2'b10); cyc(2*N_CH); fault_clr = 1'b1; cyc(1); cyc(2*N_CH + ST_CYC);
    chk("enc_recover_run", state, 1);

    // Clear on the same edge as a new ch0 fault
    wait_idx(3); set_ch(3, 2'b00); cyc(1); set_ch(3, 2'b10); cyc(N_CH);
    set_ch(0, 2'b00); fault_clr = 1'b1; cyc(1);
    chk("clr_vs_fault_state", state, 2);
    chk("clr_vs_fault_fault_ch", fault_ch, 4'b1001);
    set_ch(0, 2'b10); cyc(2*N_CH); fault_clr = 1'b1; cyc(1); cyc(2*N_CH + ST_CYC);

    // Random pair codes and clear pulses
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) begin
        int ch, r;
        ch = $urandom_range(N_CH - 1);
        r  = $urandom_range(7);
        if (r < 4)       set_ch(ch, 2'b10);
        else if (r < 6)  set_ch(ch, 2'b01);
        else if (r == 6) set_ch(ch, 2'b00);
        else             set_ch(ch, 2'b11);
      end
      if ($urandom_range(5) == 0) fault_clr = 1'b1;
      cyc(1);
    end
    ch_pn = {N_CH{2'b10}}; cyc(3*N_CH);

    // Asynchronous reset while in FAULT
    set_ch(0, 2'b11); cyc(N_CH);
    chk("pre_async_fault", state, 2);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    set_ch(0, 2'b10); rst = 1'b0; model_reset();
    cyc(N_CH + ST_CYC);
    chk("after_async_run", state, 1);

`ifdef COMPLI_SELFTEST_EN
    // Checker valid output stuck at 0 during self-test
    force dut.cls_valid = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("selftest_fail_flag", selftest_fail, 1'b1);
    chk("selftest_fail_state", state, 2);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    repeat (8) @(negedge clk);
    chk("selftest_clr_ignored", state, 2);
    chk("selftest_fail_sticky", selftest_fail, 1'b1);
    release dut.cls_valid;
`endif

    @(posedge clk); #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
